// File: rtl/conv_core_kxk_seq.sv
// conv_core_kxk_seq: time-multiplexed KERNEL x KERNEL signed fixed-point
// convolution core. One MAC per cycle over the captured window, then bias,
// round-half-up and saturation. Optional ReLU clamp on the result is enabled
// by defining CONV_RELU_EN.
module conv_core_kxk_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int KERNEL     = 3,
  parameter int FRAC_BITS  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     Weight_We,
  input  logic [((KERNEL*KERNEL > 1) ? $clog2(KERNEL*KERNEL) : 1)-1:0] Weight_Addr,
  input  logic [DATA_WIDTH-1:0]                    Weight_Data,
  input  logic [DATA_WIDTH-1:0]                    Bias,
  input  logic [KERNEL*KERNEL*DATA_WIDTH-1:0]      Data_In,
  input  logic                                     Valid_In,
  output logic                                     Ready_In,
  output logic [DATA_WIDTH-1:0]                    Data_Out,
  output logic                                     Valid_Out,
  input  logic                                     Ready_Out,
  output logic                                     Busy
);

  localparam int N         = KERNEL * KERNEL;
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(N) + 1;
  localparam int AW        = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [ACC_WIDTH-1:0] HALF =
    (FRAC_BITS > 0) ? (ACC_WIDTH'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   w_q   [N];
  logic signed [DATA_WIDTH-1:0]   win_q [N];
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic [AW-1:0]                  idx_q;
  logic [DATA_WIDTH-1:0]          data_q;
  logic                           valid_q;

  logic                           accept;
  logic                           last;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    rounded;
  logic [DATA_WIDTH-1:0]          result;

  assign Ready_In  = (state_q == IDLE);
  assign Busy      = (state_q != IDLE);
  assign Data_Out  = data_q;
  assign Valid_Out = valid_q;
  assign accept    = Valid_In && Ready_In;
  assign last      = (idx_q == AW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = MAC;
      MAC:   if (last) state_d = ROUND;
      ROUND: state_d = OUT;
      OUT:   if (Ready_Out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MAC product, rounding, saturation and optional ReLU clamp
  always_comb begin
    prod    = win_q[idx_q] * w_q[idx_q];
    rounded = (acc_q + HALF) >>> FRAC_BITS;
    if (rounded > SAT_MAX)      result = SAT_MAX[DATA_WIDTH-1:0];
    else if (rounded < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
    else                        result = rounded[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
    if (result[DATA_WIDTH-1]) result = '0;
`endif
  end

  // Weight file: writes only land in IDLE when no window is taken on that edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) w_q[i] <= '0;
    end else if (state_q == IDLE && Weight_We && !Valid_In &&
                 ({1'b0, Weight_Addr} < (AW+1)'(N))) begin
      w_q[Weight_Addr] <= Weight_Data;
    end
  end

  // Window capture, accumulation and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) win_q[i] <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          for (int unsigned i = 0; i < N; i++)
            win_q[i] <= Data_In[i*DATA_WIDTH +: DATA_WIDTH];
          acc_q <= ACC_WIDTH'($signed(Bias)) <<< FRAC_BITS;
          idx_q <= '0;
        end
        MAC: begin
          acc_q <= acc_q + ACC_WIDTH'(prod);
          idx_q <= idx_q + AW'(1);
        end
        ROUND: begin
          data_q  <= result;
          valid_q <= 1'b1;
        end
        OUT: if (Ready_Out) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_core_kxk_seq.sv
// Self-checking bench for conv_core_kxk_seq (DATA_WIDTH=16, KERNEL=3, FRAC_BITS=8).
module tb_conv_core_kxk_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         Weight_We;
  logic [3:0]   Weight_Addr;
  logic [15:0]  Weight_Data;
  logic [15:0]  Bias;
  logic [143:0] Data_In;
  logic         Valid_In;
  logic         Ready_In;
  logic [15:0]  Data_Out;
  logic         Valid_Out;
  logic         Ready_Out;
  logic         Busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] tw [9];
  logic [15:0] td [9];

  conv_core_kxk_seq #(.DATA_WIDTH(16), .KERNEL(3), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .Weight_We(Weight_We), .Weight_Addr(Weight_Addr),
    .Weight_Data(Weight_Data), .Bias(Bias), .Data_In(Data_In), .Valid_In(Valid_In),
    .Ready_In(Ready_In), .Data_Out(Data_Out), .Valid_Out(Valid_Out),
    .Ready_Out(Ready_Out), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic on real-valued fixed-point quantities
  function automatic logic [15:0] model(input logic [15:0] b);
    longint acc;
    acc = longint'($signed(b)) * 256;
    for (int i = 0; i < 9; i++)
      acc += longint'($signed(td[i])) * longint'($signed(tw[i]));
    acc = (acc + 128) >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef CONV_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc[15:0];
  endfunction

  task automatic pack();
    for (int i = 0; i < 9; i++) Data_In[i*16 +: 16] = td[i];
  endtask

  task automatic write_w(input logic [3:0] a, input logic [15:0] d);
    Weight_We = 1'b1; Weight_Addr = a; Weight_Data = d;
    tick();
    Weight_We = 1'b0;
    if (a < 9) tw[a] = d;
  endtask

  task automatic fill(input logic [15:0] wv, input logic [15:0] dv);
    for (int i = 0; i < 9; i++) begin
      write_w(4'(i), wv);
      td[i] = dv;
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin tick(); k++; end while (!Valid_Out && k < 40);
  endtask

  task automatic run_window(input string tag, input logic [15:0] b, input bit chk_lat);
    logic [15:0] exp;
    int k;
    exp = model(b);
    Bias = b; pack(); Ready_Out = 1'b1; Valid_In = 1'b1;
    k = 0;
    while (!Ready_In && k < 50) begin tick(); k++; end
    tick();
    Valid_In = 1'b0;
    wait_valid(k);
    check({tag, "_valid"}, 64'(Valid_Out), 64'd1);
    if (chk_lat) check({tag, "_latency"}, 64'(k), 64'd10);
    check({tag, "_data"}, 64'(Data_Out), 64'(exp));
    tick();
    check({tag, "_done"}, 64'(Valid_Out), 64'd0);
  endtask

  initial begin
    logic [15:0] exp_a, exp_b, b2;
    int k;
    rst = 1'b0; Weight_We = 1'b0; Weight_Addr = '0; Weight_Data = '0;
    Bias = '0; Data_In = '0; Valid_In = 1'b0; Ready_Out = 1'b1;
    for (int i = 0; i < 9; i++) begin tw[i] = '0; td[i] = '0; end
    #2;
    check("rst_valid", 64'(Valid_Out), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_ready", 64'(Ready_In), 64'd1);
    check("rst_data", 64'(Data_Out), 64'd0);
    tick(); rst = 1'b1; tick();

    // Unity kernel; out-of-range write must be ignored
    fill(16'h0100, 16'h0100);
    write_w(4'd12, 16'h7FFF);
    run_window("unity", 16'h0000, 1'b1);
    check("unity_const", 64'(Data_Out), 64'h0900);

    // Mixed signed weights with bias
    for (int i = 0; i < 9; i++) begin
      write_w(4'(i), (i == 1) ? 16'hFE00 : 16'((i + 1) * 256));
      td[i] = 16'h0080;
    end
    run_window("mixed", 16'h0100, 1'b0);
    check("mixed_const", 64'(Data_Out), 64'h1580);

    // Rounding at half LSB, both signs
    fill(16'h0000, 16'h0000);
    write_w(4'd0, 16'h0080); td[0] = 16'h0001;
    run_window("round_pos", 16'h0000, 1'b0);
    check("round_pos_const", 64'(Data_Out), 64'h0001);
    write_w(4'd0, 16'hFF80);
    run_window("round_neg", 16'h0000, 1'b0);
    check("round_neg_const", 64'(Data_Out), 64'h0000);

    // Saturation at both rails
    fill(16'h7FFF, 16'h7FFF);
    run_window("sat_pos", 16'h0000, 1'b0);
    fill(16'h7FFF, 16'h8000);
    run_window("sat_neg", 16'h0000, 1'b0);

    // Negative result: signed output or ReLU clamp
    fill(16'hFF00, 16'h0100);
    run_window("relu", 16'h0000, 1'b0);

    // Randomised windows, weights and bias
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 9; i++) begin
        write_w(4'(i), 16'($urandom));
        td[i] = 16'($urandom);
      end
      write_w(4'($urandom_range(9, 15)), 16'($urandom));
      run_window($sformatf("rand%0d", r), 16'($urandom), 1'b1);
    end

    // Backpressure with a second window waiting upstream
    for (int i = 0; i < 9; i++) td[i] = 16'($urandom_range(0, 4095));
    exp_a = model(16'h0040);
    Bias = 16'h0040; pack(); Ready_Out = 1'b0; Valid_In = 1'b1;
    check("bp_ready_idle", 64'(Ready_In), 64'd1);
    tick();
    for (int i = 0; i < 9; i++) td[i] = 16'($urandom_range(0, 4095));
    b2 = 16'hFF00;
    exp_b = model(b2);
    Bias = b2; pack();
    wait_valid(k);
    check("bp_valid", 64'(Valid_Out), 64'd1);
    check("bp_data", 64'(Data_Out), 64'(exp_a));
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", 64'(Valid_Out), 64'd1);
      check("bp_hold_data", 64'(Data_Out), 64'(exp_a));
      check("bp_hold_ready", 64'(Ready_In), 64'd0);
    end
    Ready_Out = 1'b1;
    tick();
    check("bp_release_valid", 64'(Valid_Out), 64'd0);
    check("bp_release_ready", 64'(Ready_In), 64'd1);
    check("bp_keep_data", 64'(Data_Out), 64'(exp_a));
    tick();
    check("bp_second_taken", 64'(Busy), 64'd1);
    Valid_In = 1'b0;
    wait_valid(k);
    check("bp_second_data", 64'(Data_Out), 64'(exp_b));
    tick();

    // Write collisions: at acceptance and during MAC are both dropped
    fill(16'h0100, 16'h0000);
    for (int i = 0; i < 9; i++) td[i] = 16'(i * 64);
    exp_a = model(16'h0000);
    Bias = 16'h0000; pack(); Valid_In = 1'b1;
    Weight_We = 1'b1; Weight_Addr = 4'd0; Weight_Data = 16'h1234;
    tick();
    Valid_In = 1'b0; Weight_Addr = 4'd1; Weight_Data = 16'h4321;
    tick(); tick(); tick();
    Weight_We = 1'b0;
    wait_valid(k);
    check("coll_data", 64'(Data_Out), 64'(exp_a));
    tick();
    run_window("coll_after", 16'h0000, 1'b0);

    // Asynchronous reset mid-MAC
    fill(16'h0100, 16'h0200);
    Bias = 16'h0000; pack(); Valid_In = 1'b1;
    tick();
    Valid_In = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(Valid_Out), 64'd0);
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_ready", 64'(Ready_In), 64'd1);
    check("midrst_data", 64'(Data_Out), 64'd0);
    for (int i = 0; i < 9; i++) tw[i] = '0;
    tick(); rst = 1'b1; tick();
    check("midrst_no_output", 64'(Valid_Out), 64'd0);
    run_window("midrst_zero_w", 16'h0000, 1'b1);
    check("midrst_zero_const", 64'(Data_Out), 64'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_core_kxk_seq.md
Name: conv_core_kxk_seq

Overview:
- Parametrised, time-multiplexed successor to the fixed 3x3 convolution core.
- Holds a KERNEL x KERNEL weight set in internal registers and accepts one flattened window per transaction.
- Performs one signed fixed-point multiply-accumulate per cycle, then adds bias, rounds and saturates.
- Sits between the line-buffer/window generator and the activation/pooling stage, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 16: width of data, weight, bias and result words; signed two's complement.
- KERNEL, 3: kernel side length; window size N = KERNEL*KERNEL; legal range 1..7.
- FRAC_BITS, 8: fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); legal range 0..DATA_WIDTH-1.
- Derived localparams:
  - ACC_WIDTH = 2*DATA_WIDTH + clog2(N) + 1.
  - AW = max(1, clog2(N)).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- Weight_We, input, 1: weight write strobe.
- Weight_Addr, input, AW: weight index 0..N-1.
- Weight_Data, input, DATA_WIDTH: weight value.
- Bias, input, DATA_WIDTH: bias in data format, sampled on window acceptance.
- Data_In, input, N*DATA_WIDTH: window; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- Valid_In, input, 1: window valid.
- Ready_In, output, 1: core can accept a window.
- Data_Out, output, DATA_WIDTH: result.
- Valid_Out, output, 1: result valid.
- Ready_Out, input, 1: downstream accepts the result.
- Busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All weights, window register, accumulator and index are cleared to 0.
  - Outputs: Data_Out=0, Valid_Out=0, Busy=0, Ready_In=1 (decoded from IDLE).
  - Reset mid-operation discards the in-flight window; no partial result is ever emitted.
- Weight writes:
  - A write occurs on a clock edge with Weight_We=1 while in IDLE and not accepting a window on that same edge.
  - Writes in any other state, or with Weight_Addr >= N, are dropped.
  - If Weight_We and window acceptance coincide, acceptance wins and the write is dropped.
- FSM states: IDLE, MAC, ROUND, OUT.
  - IDLE: Ready_In=1. On Valid_In&&Ready_In:
    - capture Data_In;
    - load accumulator with sign-extended Bias << FRAC_BITS;
    - set idx=0;
    - go to MAC.
  - MAC: each cycle, acc += sext(win[idx]) * sext(w[idx]) as a full 2*DATA_WIDTH signed product, then idx++. On the edge where idx==N-1, go to ROUND.
  - ROUND:
    - If FRAC_BITS>0, r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half toward +inf). If FRAC_BITS=0, r = acc.
    - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - Register the result into Data_Out, set Valid_Out=1, go to OUT.
  - OUT:
    - Data_Out and Valid_Out are held stable while Ready_Out=0.
    - On Ready_Out=1: Valid_Out is cleared at that edge and the FSM returns to IDLE.
- Latency and throughput:
  - Valid_Out rises N+1 clock edges after the accepting edge.
  - With Ready_Out tied high, minimum spacing between accepted windows is N+3 cycles.
- Ready_In is low in MAC, ROUND and OUT. Valid_In in those states is ignored, and the upstream block must hold its data.
- Data_Out keeps its last value after the handshake, until the next ROUND.
- The accumulator cannot overflow for legal parameters, because ACC_WIDTH covers N full-scale products plus the bias.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: after saturation in ROUND, a negative result is replaced by 0 before being registered. Latency is unchanged.
- Undefined: the signed saturated result is output as is.

Test Plan:
All scenarios use DATA_WIDTH=16, KERNEL=3, FRAC_BITS=8.
- Unity: all weights 0x0100, all data 0x0100, Bias 0 -> Data_Out=0x0900 (9.0); Valid_Out rises exactly 10 edges after acceptance.
- Mixed weights:
  - Stimulus: weights 1,-2,3,4,5,6,7,8,9 (0x0100,0xFE00,0x0300,...,0x0900), data all 0x0080, Bias 0x0100.
  - Required: Data_Out=0x1580 (20.5+1.0).
- Rounding and saturation:
  - Data[0]=0x0001, weight[0]=0x0080, others 0 -> 0x0001.
  - Same with weight[0]=0xFF80 -> 0x0000.
  - Data all 0x7FFF, weights all 0x7FFF -> 0x7FFF.
  - Data all 0x8000, weights all 0x7FFF -> 0x8000.
- Backpressure:
  - Stimulus: hold Ready_Out=0 for 5 cycles after Valid_Out rises, with a second window presented throughout.
  - Required: Data_Out stable, Ready_In=0, second window not taken. It is accepted 2 edges after Ready_Out=1.
- Reset and write collision:
  - Assert rst=0 mid-MAC -> Valid_Out=0, Busy=0 and Ready_In=1 immediately; weights read back as 0 (a subsequent window gives 0x0000 with Bias 0).
  - Weight_We pulsed during MAC -> weights unchanged.
- ReLU: data all 0x0100, weights all 0xFF00 -> 0xF700 without CONV_RELU_EN, 0x0000 with it.
